mult_div_unit_div: RTL and testbench



---
 rtl/mult_div_unit_div.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit_div.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_div.sv
// ---------------------------------------------------------------------------
// mult_div_unit_div
//
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// A divide accepted in IDLE spends WIDTH cycles in BUSY (one quotient bit
// per cycle) and then one cycle in DONE, where ready pulses and result holds
// {remainder, quotient}. The hazard unit stalls EX while start & ~ready.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   resetn     - asynchronous active-low reset
//   start      - level request, held high while the divide sits in EX
//   signed_div - 1 = DIV (two's complement), 0 = DIVU
//   a, b       - dividend and divisor, sampled only in the accepting cycle
//   annul      - abort the current operation, return to IDLE
//   ready      - one-cycle completion pulse (decoded from the state register)
//   result     - {remainder, quotient}; upper half -> HI, lower half -> LO
// ---------------------------------------------------------------------------
module mult_div_unit_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t nextState;

    // Partial remainder and quotient together form the 64-bit shift register;
    // the quotient half starts out holding the dividend magnitude.
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quotReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] dividendRaw;
    logic             quotNeg;
    logic             remNeg;
    logic             divByZero;
    logic [5:0]       stepCount;

    logic             aIsNeg;
    logic             bIsNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   shiftRem;
    logic             noBorrow;
    logic [WIDTH-1:0] trialDiff;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuot;
    logic [WIDTH-1:0] finalRem;
    logic [WIDTH-1:0] finalQuot;
    logic             lastStep;
    logic             accept;

    // Operand magnitudes in plain unsigned arithmetic, so the most negative
    // value maps onto itself (|0x80000000| = 0x80000000).
    always_comb begin
        aIsNeg = signed_div & a[WIDTH-1];
        bIsNeg = signed_div & b[WIDTH-1];
        aMag   = aIsNeg ? (~a + WIDTH'(1)) : a;
        bMag   = bIsNeg ? (~b + WIDTH'(1)) : b;
        accept = start & ~annul;
    end

    // One restoring step. The shifted remainder needs one extra bit because
    // twice a remainder just below the divisor can exceed WIDTH bits; the
    // difference itself always fits back into WIDTH bits.
    always_comb begin
        shiftRem  = {remReg, quotReg[WIDTH-1]};
        noBorrow  = (shiftRem >= {1'b0, divisorReg});
        trialDiff = shiftRem[WIDTH-1:0] - divisorReg;
        nextRem   = noBorrow ? trialDiff : shiftRem[WIDTH-1:0];
        nextQuot  = {quotReg[WIDTH-2:0], noBorrow};
        finalRem  = remNeg  ? (~nextRem  + WIDTH'(1)) : nextRem;
        finalQuot = quotNeg ? (~nextQuot + WIDTH'(1)) : nextQuot;
        lastStep  = (stepCount == 6'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. DONE always falls back to IDLE so a start that is
    // still high while the instruction leaves EX cannot restart the unit;
    // annul overrides everything.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = BUSY;
            BUSY:    if (lastStep) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (annul) nextState = IDLE;
    end

    assign ready = (state == DONE);

    // Datapath. The result is written on the edge that enters DONE, using the
    // final step's combinational values, so it is valid together with ready.
    // It is never cleared by a new start, only replaced at the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remReg      <= '0;
            quotReg     <= '0;
            divisorReg  <= '0;
            dividendRaw <= '0;
            quotNeg     <= 1'b0;
            remNeg      <= 1'b0;
            divByZero   <= 1'b0;
            stepCount   <= '0;
            result      <= '0;
        end else begin
            if (state == IDLE && accept) begin
                remReg      <= '0;
                quotReg     <= aMag;
                divisorReg  <= bMag;
                dividendRaw <= a;
                quotNeg     <= aIsNeg ^ bIsNeg;
                remNeg      <= aIsNeg;
                divByZero   <= (b == '0);
                stepCount   <= '0;
            end else if (state == BUSY && !annul) begin
                remReg    <= nextRem;
                quotReg   <= nextQuot;
                stepCount <= stepCount + 6'd1;
                if (lastStep) begin
                    result <= divByZero ? {dividendRaw, {WIDTH{1'b1}}}
                                        : {finalRem, finalQuot};
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit_div.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit_div
//
// Scoreboard bench for mult_div_unit_div. Each accepted divide pushes its
// expected {remainder, quotient} and the cycle in which ready must appear;
// a monitor pops and compares whenever ready is seen.
// ---------------------------------------------------------------------------
module tb_mult_div_unit_div;

    typedef struct {
        logic [63:0] value;
        int          cycle;
    } ExpectEntry;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signedDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        ready;
    logic [63:0] result;

    int          checks;
    int          errors;
    int          cycleCount;
    logic [63:0] lastExpected;
    ExpectEntry  scoreboard[$];

    mult_div_unit_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signedDiv),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .ready      (ready),
        .result     (result)
    );

    // Free-running clock and a cycle index that advances at each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCount = 0;
    always @(posedge clk) cycleCount = cycleCount + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding entry,
    // both in value and in the cycle it shows up.
    always @(negedge clk) begin
        if (resetn && ready) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpectedReady", 64'(cycleCount), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ExpectEntry e;
                e = scoreboard.pop_front();
                checkOutput("readyCycle", 64'(cycleCount), 64'(e.cycle));
                checkOutput("result", result, e.value);
            end
        end
    end

    // One divide: start held from cycle 0 through cycle 33, optional operand
    // scrambling after cycle 0, then dropped so the unit returns to IDLE.
    task automatic applyStimulus(input logic sgn, input logic [31:0] opA,
                                 input logic [31:0] opB, input logic [63:0] expected,
                                 input bit scramble);
        ExpectEntry e;
        @(negedge clk);
        start     = 1'b1;
        signedDiv = sgn;
        a         = opA;
        b         = opB;
        e.value   = expected;
        e.cycle   = cycleCount + 33;
        scoreboard.push_back(e);
        lastExpected = expected;
        repeat (33) begin
            @(negedge clk);
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("drained", 64'(scoreboard.size()), 64'd0);
        checkOutput("readyAfterDone", {63'd0, ready}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        ExpectEntry  e;
        checks       = 0;
        errors       = 0;
        lastExpected = '0;
        resetn       = 1'b0;
        start        = 1'b0;
        signedDiv    = 1'b0;
        a            = '0;
        b            = '0;
        annul        = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("resetReady", {63'd0, ready}, 64'd0);
        checkOutput("resetResult", result, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Unsigned, signed sign combinations and corner cases.
        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        applyStimulus(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
        applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0001, {32'h8000_0000, 32'd0}, 1'b0);

        // Operands moving after the accepting cycle must not matter.
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'h0001_FFFF);
            applyStimulus(1'b0, ra, rb, {ra % rb, ra / rb}, 1'b1);
        end

        // Annul in cycle 10, new divide accepted in cycle 12.
        @(negedge clk);
        start     = 1'b1;
        signedDiv = 1'b0;
        a         = 32'd1000;
        b         = 32'd3;
        repeat (10) @(negedge clk);
        start = 1'b0;
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        checkOutput("annulResultHeld", result, lastExpected);
        @(negedge clk);
        checkOutput("annulResultHeld2", result, lastExpected);
        start   = 1'b1;
        a       = 32'd9;
        b       = 32'd3;
        e.value = {32'd0, 32'd3};
        e.cycle = cycleCount + 33;
        scoreboard.push_back(e);
        lastExpected = e.value;
        repeat (33) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("annulDrained", 64'(scoreboard.size()), 64'd0);

        // Back-to-back with start held high across both instructions.
        @(negedge clk);
        start     = 1'b1;
        signedDiv = 1'b0;
        a         = 32'd100;
        b         = 32'd7;
        e.value   = {32'd2, 32'd14};
        e.cycle   = cycleCount + 33;
        scoreboard.push_back(e);
        repeat (33) @(negedge clk);
        a       = 32'd50;
        b       = 32'd5;
        e.value = {32'd0, 32'd10};
        e.cycle = cycleCount + 34;
        scoreboard.push_back(e);
        lastExpected = e.value;
        @(negedge clk);
        checkOutput("b2bReadyLowCycle34", {63'd0, ready}, 64'd0);
        repeat (33) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2bDrained", 64'(scoreboard.size()), 64'd0);

        // Reset asserted mid-operation clears outputs at once.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        checkOutput("midResetReady", {63'd0, ready}, 64'd0);
        checkOutput("midResetResult", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("postResetReady", {63'd0, ready}, 64'd0);
        checkOutput("postResetResult", result, 64'd0);

        // A fresh divide after reset still shows the full fixed latency.
        applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

        checkOutput("finalQueueEmpty", 64'(scoreboard.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
